// File: rtl/muldiv_ctrl_pkg.sv
// Shared types and decode helpers for the iterative multiply/divide sequencer.
// M-extension op encodings live here alongside the existing MUL ops.
package muldiv_ctrl_pkg;

   localparam int XLEN_DEFAULT = 32;

   typedef enum logic [3:0] {
      ALUOP_MUL    = 4'h0,
      ALUOP_MULH   = 4'h1,
      ALUOP_MULHSU = 4'h2,
      ALUOP_MULHU  = 4'h3,
      ALUOP_DIV    = 4'h4,
      ALUOP_DIVU   = 4'h5,
      ALUOP_REM    = 4'h6,
      ALUOP_REMU   = 4'h7
   } aluop_e;

   function automatic logic op_is_div(aluop_e op);
      return op inside {ALUOP_DIV, ALUOP_DIVU, ALUOP_REM, ALUOP_REMU};
   endfunction

   // High result half means product[2*XLEN-1:XLEN] for MULH*, remainder for REM*.
   function automatic logic op_sel_hi(aluop_e op);
      return op inside {ALUOP_MULH, ALUOP_MULHSU, ALUOP_MULHU, ALUOP_REM, ALUOP_REMU};
   endfunction

   // {a_signed, b_signed}; MUL counts as signed since its low half is sign-agnostic.
   function automatic logic [1:0] op_sgn(aluop_e op);
      case (op)
         ALUOP_MUL, ALUOP_MULH, ALUOP_DIV, ALUOP_REM: return 2'b11;
         ALUOP_MULHSU:                                return 2'b10;
         default:                                     return 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// EX/MEM-facing handshake bundle of the multiply/divide sequencer.
interface muldiv_ctrl_if import muldiv_ctrl_pkg::*; #(parameter int XLEN = XLEN_DEFAULT) ();

   logic            req_valid;
   aluop_e          req_op;
   logic [XLEN-1:0] req_a;
   logic [XLEN-1:0] req_b;
   logic            req_ready;
   logic            flush;
   logic            out_valid;
   logic [XLEN-1:0] out_data;
   logic            out_ready;
   logic            stall;

   modport master (
      output req_valid, req_op, req_a, req_b, flush, out_ready,
      input  req_ready, out_valid, out_data, stall
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, flush, out_ready,
      output req_ready, out_valid, out_data, stall
   );

endinterface

// File: rtl/muldiv_iter.sv
// One combinational step of the multiply (add + shift right) or restoring divide
// (shift left + trial subtract) loop on the {acc, shreg} pair.
module muldiv_iter import muldiv_ctrl_pkg::*; #(parameter int XLEN = XLEN_DEFAULT) (
   input  logic [2*XLEN-1:0] step_in,
   input  logic [XLEN-1:0]   operand,
   input  logic              div_mode,
   output logic [2*XLEN-1:0] step_out
);

   logic [XLEN-1:0] acc;
   logic [XLEN-1:0] shreg;
   logic [XLEN:0]   sum;
   logic [XLEN:0]   rem_trial;
   logic [XLEN-1:0] diff;
   logic            ge;

   assign acc       = step_in[2*XLEN-1:XLEN];
   assign shreg     = step_in[XLEN-1:0];
   assign sum       = {1'b0, acc} + {1'b0, (shreg[0] ? operand : '0)};
   assign rem_trial = {acc, shreg[XLEN-1]};
   assign ge        = rem_trial >= {1'b0, operand};
   // Only used when ge, so the modulo-2^XLEN difference is exact.
   assign diff      = rem_trial[XLEN-1:0] - operand;

   always_comb begin
      step_out = {sum, shreg[XLEN-1:1]};
      if (div_mode) begin
         step_out = {(ge ? diff : rem_trial[XLEN-1:0]), shreg[XLEN-2:0], ge};
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative M-extension sequencer: IDLE -> PREP -> RUN (XLEN steps) -> FIX -> DONE.
// Optional result-reuse entry for MULH->MUL / DIV->REM pairs under MULDIV_FUSE_EN.
module muldiv_ctrl import muldiv_ctrl_pkg::*; #(parameter int XLEN = XLEN_DEFAULT) (
   input  logic          clk,
   input  logic          reset,
   muldiv_ctrl_if.slave  bus
);

   localparam int CNT_W = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE} state_e;

   state_e          state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   aluop_e          op_reg, op_next;
   logic [XLEN-1:0] a_reg, a_next, b_reg, b_next;
   logic [XLEN-1:0] acc_reg, acc_next, shreg_reg, shreg_next, opnd_reg, opnd_next;
   logic            neg_res_reg, neg_res_next, neg_rem_reg, neg_rem_next;
   logic            out_valid_reg, out_valid_next;
   logic [XLEN-1:0] out_data_reg, out_data_next;

   logic            accept, div_zero, div_ovf, shortcut, div_mode;
   logic [1:0]      req_sgn, cur_sgn;
   logic [XLEN-1:0] short_hi, short_lo;
   logic            a_neg, b_neg;
   logic [XLEN-1:0] abs_a, abs_b;
   logic [2*XLEN-1:0] step_next, prod;
   logic [XLEN-1:0] quot, rem, fix_hi, fix_lo;
   logic            store_en, fuse_hit;
   logic [XLEN-1:0] store_hi, store_lo, fuse_hi, fuse_lo;

   assign accept   = bus.req_valid & (state_reg == S_IDLE) & ~bus.flush;
   assign req_sgn  = op_sgn(bus.req_op);
   assign div_zero = op_is_div(bus.req_op) & (bus.req_b == '0);
   assign div_ovf  = op_is_div(bus.req_op) & req_sgn[0] & (bus.req_a == MIN_INT) & (bus.req_b == '1);
   assign shortcut = div_zero | div_ovf;
   assign short_lo = div_zero ? '1 : MIN_INT;
   assign short_hi = div_zero ? bus.req_a : '0;

   assign div_mode = op_is_div(op_reg);
   assign cur_sgn  = op_sgn(op_reg);
   assign a_neg    = cur_sgn[1] & a_reg[XLEN-1];
   assign b_neg    = cur_sgn[0] & b_reg[XLEN-1];
   assign abs_a    = a_neg ? -a_reg : a_reg;
   assign abs_b    = b_neg ? -b_reg : b_reg;

   // Remainder follows the dividend's sign; quotient/product follow a_neg ^ b_neg.
   assign prod   = neg_res_reg ? -{acc_reg, shreg_reg} : {acc_reg, shreg_reg};
   assign quot   = neg_res_reg ? -shreg_reg : shreg_reg;
   assign rem    = neg_rem_reg ? -acc_reg : acc_reg;
   assign fix_hi = div_mode ? rem  : prod[2*XLEN-1:XLEN];
   assign fix_lo = div_mode ? quot : prod[XLEN-1:0];

   muldiv_iter #(.XLEN(XLEN)) u_iter (
      .step_in  ({acc_reg, shreg_reg}),
      .operand  (opnd_reg),
      .div_mode (div_mode),
      .step_out (step_next)
   );

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      op_next        = op_reg;
      a_next         = a_reg;
      b_next         = b_reg;
      acc_next       = acc_reg;
      shreg_next     = shreg_reg;
      opnd_next      = opnd_reg;
      neg_res_next   = neg_res_reg;
      neg_rem_next   = neg_rem_reg;
      out_valid_next = out_valid_reg;
      out_data_next  = out_data_reg;
      store_en       = 1'b0;
      store_hi       = fix_hi;
      store_lo       = fix_lo;
      if (bus.flush) begin
         state_next     = S_IDLE;
         out_valid_next = 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: if (accept) begin
               op_next = bus.req_op;
               a_next  = bus.req_a;
               b_next  = bus.req_b;
               if (shortcut) begin
                  state_next     = S_DONE;
                  out_valid_next = 1'b1;
                  out_data_next  = op_sel_hi(bus.req_op) ? short_hi : short_lo;
                  store_en       = 1'b1;
                  store_hi       = short_hi;
                  store_lo       = short_lo;
               end else if (fuse_hit) begin
                  state_next     = S_DONE;
                  out_valid_next = 1'b1;
                  out_data_next  = op_sel_hi(bus.req_op) ? fuse_hi : fuse_lo;
               end else begin
                  state_next = S_PREP;
               end
            end
            S_PREP: begin
               acc_next     = '0;
               cnt_next     = CNT_W'(XLEN - 1);
               neg_res_next = a_neg ^ b_neg;
               neg_rem_next = a_neg;
               shreg_next   = div_mode ? abs_a : abs_b;
               opnd_next    = div_mode ? abs_b : abs_a;
               state_next   = S_RUN;
            end
            S_RUN: begin
               {acc_next, shreg_next} = step_next;
               if (cnt_reg == '0) begin
                  state_next = S_FIX;
               end else begin
                  cnt_next = cnt_reg - 1'b1;
               end
            end
            S_FIX: begin
               state_next     = S_DONE;
               out_valid_next = 1'b1;
               out_data_next  = op_sel_hi(op_reg) ? fix_hi : fix_lo;
               store_en       = 1'b1;
            end
            S_DONE: if (bus.out_ready) begin
               state_next     = S_IDLE;
               out_valid_next = 1'b0;
            end
            default: state_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= S_IDLE;
         cnt_reg       <= '0;
         op_reg        <= ALUOP_MUL;
         a_reg         <= '0;
         b_reg         <= '0;
         acc_reg       <= '0;
         shreg_reg     <= '0;
         opnd_reg      <= '0;
         neg_res_reg   <= 1'b0;
         neg_rem_reg   <= 1'b0;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         op_reg        <= op_next;
         a_reg         <= a_next;
         b_reg         <= b_next;
         acc_reg       <= acc_next;
         shreg_reg     <= shreg_next;
         opnd_reg      <= opnd_next;
         neg_res_reg   <= neg_res_next;
         neg_rem_reg   <= neg_rem_next;
         out_valid_reg <= out_valid_next;
         out_data_reg  <= out_data_next;
      end
   end

`ifdef MULDIV_FUSE_EN
   logic            fuse_valid_reg, fuse_div_reg;
   logic [1:0]      fuse_sgn_reg;
   logic [XLEN-1:0] fuse_a_reg, fuse_b_reg, fuse_hi_reg, fuse_lo_reg;

   assign fuse_hit = fuse_valid_reg & (fuse_a_reg == bus.req_a) & (fuse_b_reg == bus.req_b) &
                     (fuse_div_reg == op_is_div(bus.req_op)) & (fuse_sgn_reg == req_sgn);
   assign fuse_hi  = fuse_hi_reg;
   assign fuse_lo  = fuse_lo_reg;

   // Keyed on the operands the completing op was accepted with; survives flush.
   always_ff @(posedge clk) begin
      if (reset) begin
         fuse_valid_reg <= 1'b0;
         fuse_div_reg   <= 1'b0;
         fuse_sgn_reg   <= '0;
         fuse_a_reg     <= '0;
         fuse_b_reg     <= '0;
         fuse_hi_reg    <= '0;
         fuse_lo_reg    <= '0;
      end else if (store_en & ~bus.flush) begin
         fuse_valid_reg <= 1'b1;
         fuse_div_reg   <= op_is_div(op_next);
         fuse_sgn_reg   <= op_sgn(op_next);
         fuse_a_reg     <= a_next;
         fuse_b_reg     <= b_next;
         fuse_hi_reg    <= store_hi;
         fuse_lo_reg    <= store_lo;
      end
   end
`else
   logic unused_store;
   assign fuse_hit     = 1'b0;
   assign fuse_hi      = '0;
   assign fuse_lo      = '0;
   assign unused_store = ^{store_en, store_hi, store_lo};
`endif

   assign bus.req_ready = (state_reg == S_IDLE);
   assign bus.out_valid = out_valid_reg;
   assign bus.out_data  = out_data_reg;
   assign bus.stall     = bus.req_valid & ~(out_valid_reg & bus.out_ready);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: expected result/latency queued at accept, checked on out_valid.
// Latency expectations follow MULDIV_FUSE_EN when it is defined.
module tb_muldiv_ctrl;
   import muldiv_ctrl_pkg::*;

   localparam int XL = 32;
   localparam logic [31:0] MIN_INT = 32'h8000_0000;

   logic clk = 1'b0;
   logic reset = 1'b1;

   muldiv_ctrl_if #(.XLEN(XL)) bus ();

   muldiv_ctrl #(.XLEN(XL)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail = 0;
   logic [31:0] q_data[$];
   int          q_lat[$];
   int          q_acc[$];
   int          acc_cyc = 0;
   bit          seen = 1'b0;
   logic [31:0] held_exp = '0;

`ifdef MULDIV_FUSE_EN
   bit          f_v = 1'b0;
   logic [31:0] f_a, f_b;
   bit          f_d;
   logic [1:0]  f_s;
`endif

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] model(aluop_e op, logic [31:0] a, logic [31:0] b);
      logic signed [63:0] sa, sb, p;
      logic [63:0] pu;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      case (op)
         ALUOP_MUL:    begin p = sa * sb; return p[31:0]; end
         ALUOP_MULH:   begin p = sa * sb; return p[63:32]; end
         ALUOP_MULHSU: begin p = sa * $signed({32'b0, b}); return p[63:32]; end
         ALUOP_MULHU:  begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
         ALUOP_DIV: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == MIN_INT && b == 32'hFFFF_FFFF) return MIN_INT;
            p = sa / sb;
            return p[31:0];
         end
         ALUOP_REM: begin
            if (b == 0) return a;
            if (a == MIN_INT && b == 32'hFFFF_FFFF) return 32'h0;
            p = sa % sb;
            return p[31:0];
         end
         ALUOP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         ALUOP_REMU: return (b == 0) ? a : a % b;
         default:    return 32'h0;
      endcase
   endfunction

   function automatic bit is_div(aluop_e op);
      return op inside {ALUOP_DIV, ALUOP_DIVU, ALUOP_REM, ALUOP_REMU};
   endfunction

`ifdef MULDIV_FUSE_EN
   function automatic logic [1:0] sgn_of(aluop_e op);
      if (op inside {ALUOP_MUL, ALUOP_MULH, ALUOP_DIV, ALUOP_REM}) return 2'b11;
      if (op == ALUOP_MULHSU) return 2'b10;
      return 2'b00;
   endfunction

   task automatic fuse_note(aluop_e op, logic [31:0] a, logic [31:0] b);
      f_v = 1'b1; f_a = a; f_b = b; f_d = is_div(op); f_s = sgn_of(op);
   endtask
`endif

   function automatic int lat_of(aluop_e op, logic [31:0] a, logic [31:0] b);
      if (is_div(op) && b == 0) return 1;
      if ((op == ALUOP_DIV || op == ALUOP_REM) && a == MIN_INT && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FUSE_EN
      if (f_v && f_a == a && f_b == b && f_d == is_div(op) && f_s == sgn_of(op)) return 1;
`endif
      return 35;
   endfunction

   // Called just after a posedge; returns just after the accepting edge.
   task automatic send(aluop_e op, logic [31:0] a, logic [31:0] b);
      int n = 0;
      bus.req_op    = op;
      bus.req_a     = a;
      bus.req_b     = b;
      bus.req_valid = 1'b1;
      @(negedge clk);
      while (!(bus.req_ready && !bus.flush) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("accept_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      acc_cyc = cyc;
   endtask

   task automatic wait_done(input int hold);
      int n = 0;
      int held = 0;
      bit done = 1'b0;
      bus.out_ready = (hold == 0);
      while (!done && n < 200) begin
         @(negedge clk);
         if (bus.out_valid && bus.out_ready) begin
            done = 1'b1;
         end else begin
            if (bus.out_valid) held++;
            @(posedge clk); #1;
            bus.out_ready = (held >= hold);
         end
         n++;
      end
      if (!done) check("done_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      bus.out_ready = 1'b1;
   endtask

   task automatic run_op(aluop_e op, logic [31:0] a, logic [31:0] b, logic [31:0] exp, input int hold);
      int lat;
      lat = lat_of(op, a, b);
      send(op, a, b);
      q_data.push_back(exp);
      q_lat.push_back(lat);
      q_acc.push_back(acc_cyc);
      wait_done(hold);
`ifdef MULDIV_FUSE_EN
      fuse_note(op, a, b);
`endif
   endtask

   // Monitor: pop on the first cycle of out_valid; check hold behaviour while stalled.
   always @(negedge clk) begin
      if (!reset && bus.out_valid) begin
         if (!seen) begin
            seen = 1'b1;
            if (q_data.size() == 0) begin
               check("unexpected_valid", 64'd1, 64'd0);
            end else begin
               held_exp = q_data.pop_front();
               check("data", 64'(bus.out_data), 64'(held_exp));
               check("latency", 64'(cyc - q_acc.pop_front() + 1), 64'(q_lat.pop_front()));
               if (bus.out_ready) check("stall_at_fire", 64'(bus.stall), 64'd0);
            end
         end else if (!bus.out_ready) begin
            check("hold_data", 64'(bus.out_data), 64'(held_exp));
            check("hold_stall", 64'(bus.stall), 64'd1);
         end
      end else begin
         seen = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      bit rose;
      logic [31:0] ra, rb;
      aluop_e rop;
      bus.req_valid = 1'b0;
      bus.req_op    = ALUOP_MUL;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_out_valid", 64'(bus.out_valid), 64'd0);
      check("reset_out_data", 64'(bus.out_data), 64'd0);
      check("reset_req_ready", 64'(bus.req_ready), 64'd1);
      check("reset_stall", 64'(bus.stall), 64'd0);
      @(posedge clk); #1;

      run_op(ALUOP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 0);
      run_op(ALUOP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 0);
      run_op(ALUOP_DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, 0);
      run_op(ALUOP_REMU, 32'd100, 32'd0, 32'd100, 0);
      run_op(ALUOP_DIV, MIN_INT, 32'hFFFF_FFFF, MIN_INT, 0);
      run_op(ALUOP_REM, MIN_INT, 32'hFFFF_FFFF, 32'd0, 0);
      run_op(ALUOP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 0);
      run_op(ALUOP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 0);
      run_op(ALUOP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
      run_op(ALUOP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

      // Request presented together with flush in IDLE must not be taken.
      bus.req_op = ALUOP_MUL; bus.req_a = 32'd5; bus.req_b = 32'd5;
      bus.req_valid = 1'b1; bus.flush = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("flush_idle_ready", 64'(bus.req_ready), 64'd1);
      check("flush_idle_valid", 64'(bus.out_valid), 64'd0);
      @(posedge clk); #1;
      bus.flush = 1'b0; bus.req_valid = 1'b0;

      // Flush in the 10th RUN cycle.
      send(ALUOP_MUL, 32'd7, 32'd9);
      repeat (10) @(posedge clk);
      #1 bus.flush = 1'b1;
      @(negedge clk);
      check("run_stall", 64'(bus.stall), 64'd1);
      @(posedge clk); #1;
      bus.flush = 1'b0; bus.req_valid = 1'b0;
      @(negedge clk);
      check("flush_req_ready", 64'(bus.req_ready), 64'd1);
      rose = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (bus.out_valid) rose = 1'b1;
      end
      check("flush_no_valid", 64'(rose), 64'd0);
      @(posedge clk); #1;
      run_op(ALUOP_MUL, 32'd3, 32'd5, 32'd15, 0);

      run_op(ALUOP_MUL, 32'd12345, 32'd678, 32'd8369910, 5);
      run_op(ALUOP_DIV, 32'd20, 32'd3, 32'd6, 0);
      run_op(ALUOP_REM, 32'd20, 32'd3, 32'd2, 0);

      for (int i = 0; i < 10; i++) begin
         rop = aluop_e'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = (i % 4 == 3) ? 32'd0 : ((i % 4 == 1) ? $urandom_range(1, 300) : $urandom);
         run_op(rop, ra, rb, model(rop, ra, rb), 0);
      end

      // Reset mid-operation: discard and drop the reuse entry.
      send(ALUOP_DIVU, 32'd20, 32'd3);
      repeat (5) @(posedge clk);
      #1 reset = 1'b1; bus.req_valid = 1'b0;
`ifdef MULDIV_FUSE_EN
      f_v = 1'b0;
`endif
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check("midreset_valid", 64'(bus.out_valid), 64'd0);
      check("midreset_ready", 64'(bus.req_ready), 64'd1);
      @(posedge clk); #1;
      run_op(ALUOP_REM, 32'd20, 32'd3, 32'd2, 0);

      repeat (3) @(posedge clk);
      check("queue_drained", 64'(q_data.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
